// File: rtl/frame_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_dispatch_arbiter
// Purpose  : Round-robin dispatcher that shares a single frame controller
//            among NUM_REQ descriptor requesters. Launches one frame at a
//            time, bounds it with a watchdog, and reports a completion
//            record carrying the owning requester ID and status.
// Revision : 1.0 - initial release
// ============================================================================
module frame_dispatch_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  // descriptor requesters
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr,
  input  logic [NUM_REQ*16-1:0]         req_frame_depth,
  input  logic [NUM_REQ*8-1:0]          req_lane_stride,
  // frame controller side
  output logic [ADDR_WIDTH-1:0]         fc_base_addr,
  output logic [15:0]                   fc_frame_depth,
  output logic [7:0]                    fc_lane_stride,
  output logic                          fc_start_trigger,
  input  logic                          fc_frame_done,
  // completion reporting
  output logic                          cmp_valid,
  input  logic                          cmp_ready,
  output logic [ID_W-1:0]               cmp_id,
  output logic                          cmp_timeout,
  output logic                          cmp_err,
  output logic                          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_CMPL   = 2'd3
  } state_t;

  // Watchdog terminal count: the TIMEOUT_CYCLES-th RUN cycle has count TIMEOUT_CYCLES-1.
  localparam logic [31:0] c_WD_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam bit          c_WD_EN   = (TIMEOUT_CYCLES != 0);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [31:0]           r_wd_cnt;
  logic                  r_first_run;
  logic [ADDR_WIDTH-1:0] r_fc_base;
  logic [15:0]           r_fc_depth;
  logic [7:0]            r_fc_stride;
  logic [ID_W-1:0]       r_cmp_id;
  logic                  r_cmp_timeout;
  logic                  r_cmp_err;

  logic [ADDR_WIDTH-1:0] w_base   [NUM_REQ];
  logic [15:0]           w_depth  [NUM_REQ];
  logic [7:0]            w_stride [NUM_REQ];
  logic                  w_grant_vld;
  logic [ID_W-1:0]       w_grant_idx;
  logic [ID_W-1:0]       w_cand;
  logic                  w_accept;
  logic                  w_zero_depth;
  logic                  w_done_ok;
  logic                  w_wd_expire;

  // Split the flat descriptor buses into per-requester fields.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_base[gi]   = req_base_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_depth[gi]  = req_frame_depth[gi*16 +: 16];
      assign w_stride[gi] = req_lane_stride[gi*8 +: 8];
    end
  endgenerate

  // Round-robin search: scan from the farthest candidate to the nearest so the
  // requester closest after r_rr_ptr overwrites any earlier match and wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_accept     = (r_state == ST_IDLE) && w_grant_vld;
  assign w_zero_depth = (w_depth[w_grant_idx] == 16'd0);
  // The done level seen in the first RUN cycle is left over from the previous frame.
  assign w_done_ok    = fc_frame_done && !r_first_run;
  assign w_wd_expire  = c_WD_EN && (r_wd_cnt == c_WD_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt      = r_state;
    req_ready        = '0;
    fc_start_trigger = 1'b0;
    cmp_valid        = 1'b0;
    busy             = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // Ready is masked during reset so requesters see the reset value.
        if (w_grant_vld && !reset) req_ready[w_grant_idx] = 1'b1;
        if (w_accept) w_state_nxt = w_zero_depth ? ST_CMPL : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        fc_start_trigger = 1'b1;
        w_state_nxt      = ST_RUN;
      end
      ST_RUN: begin
        if (w_done_ok || w_wd_expire) w_state_nxt = ST_CMPL;
      end
      ST_CMPL: begin
        cmp_valid = 1'b1;
        if (cmp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winning descriptor and owner on accept; held until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fc_base   <= '0;
      r_fc_depth  <= '0;
      r_fc_stride <= '0;
      r_cmp_id    <= '0;
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_fc_base   <= w_base[w_grant_idx];
      r_fc_depth  <= w_depth[w_grant_idx];
      r_fc_stride <= w_stride[w_grant_idx];
      r_cmp_id    <= w_grant_idx;
      r_rr_ptr    <= w_grant_idx;
    end
  end

  // Completion status: error decided at accept, timeout decided when RUN ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmp_err     <= 1'b0;
      r_cmp_timeout <= 1'b0;
    end else if (w_accept) begin
      r_cmp_err     <= w_zero_depth;
      r_cmp_timeout <= 1'b0;
    end else if (r_state == ST_RUN && !w_done_ok && w_wd_expire) begin
      r_cmp_timeout <= 1'b1;
    end
  end

  // Watchdog counter and first-RUN-cycle marker, both armed in LAUNCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt    <= '0;
      r_first_run <= 1'b0;
    end else if (r_state == ST_LAUNCH) begin
      r_wd_cnt    <= '0;
      r_first_run <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_wd_cnt    <= r_wd_cnt + 32'd1;
      r_first_run <= 1'b0;
    end
  end

  assign fc_base_addr   = r_fc_base;
  assign fc_frame_depth = r_fc_depth;
  assign fc_lane_stride = r_fc_stride;
  assign cmp_id         = r_cmp_id;
  assign cmp_timeout    = r_cmp_timeout;
  assign cmp_err        = r_cmp_err;

endmodule
`default_nettype wire
